// File: rtl/lmem_port_arbiter_pkg.sv
// lmem_port_arbiter_pkg
// Shared definitions for the LMEM port arbiter: FSM state encodings and the
// ID-width helper used by the top level and the round-robin picker.
// Optional feature macro used by the top level: LMEM_ARB_LOCK_EN.
package lmem_port_arbiter_pkg;

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Ceiling log2 with a floor of 1 so that a 1-bit ID always exists.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lmem_port_arbiter_rr_picker.sv
// lmem_port_arbiter_rr_picker
// Combinational rotate-priority picker: returns the first valid requester
// at or above rr_ptr, wrapping to the lowest valid requester.
// Ports:
//   req_valid  in   NREQ  candidate requests
//   rr_ptr     in   IDW   highest-priority requester index
//   grant      out  NREQ  one-hot grant (zero when nothing valid)
//   g          out  IDW   binary index of the granted requester
//   any        out  1     at least one candidate valid
module lmem_port_arbiter_rr_picker
  import lmem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  g,
  output logic            any
);

  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] pool;

  always_comb begin
    hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req_valid[i] && (i >= int'(rr_ptr));
    end
    // Requests at or above the pointer win; otherwise wrap to the bottom.
    pool = (|hi) ? hi : req_valid;
    g = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pool[i]) g = IDW'(i);
    end
    any   = |req_valid;
    grant = any ? (NREQ'(1) << g) : '0;
  end

endmodule

// File: rtl/lmem_port_arbiter.sv
// lmem_port_arbiter
// Shares one LMEM block-RAM port between NREQ requesters with round-robin
// grant and routes the 1-cycle-latency read data back to the issuer.
// Optional feature: define LMEM_ARB_LOCK_EN to enable locked bursts
// (owner keeps the port for up to LOCK_MAX consecutive accepts).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready one-hot or zero)
//   req_we/req_lock      per-requester write flag / lock request
//   req_addr/req_data    flattened per-requester address / write data
//   rsp_valid/rsp_data   one-hot read strobe, shared read data
//   mem_we/addr/data     to LMEM port; mem_q registered read data from it
module lmem_port_arbiter
  import lmem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int NREQ       = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  input  logic [DATA_WIDTH-1:0]      mem_q
);

  localparam int IDW = clog2_min1(NREQ);

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
      $error("lmem_port_arbiter: NREQ must be in 2..8");
    end
  endgenerate

  logic [IDW-1:0]        rr_ptr;
  logic [NREQ-1:0]       cand;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        g;
  logic                  any;
  logic                  act;
  logic                  tag_vld_p1;
  logic [IDW-1:0]        tag_g_p1;
  logic [DATA_WIDTH-1:0] rsp_hold_p1;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef LMEM_ARB_LOCK_EN
  localparam int CW = clog2_min1(LOCK_MAX + 1);
  logic [0:0]     state;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  lock_cnt;
  // While locked only the owner is a candidate, even when it is idle.
  assign cand = (state == LOCKED) ? (req_valid & (NREQ'(1) << owner)) : req_valid;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign cand = req_valid;
`endif

  // Stage p0: grant and LMEM request
  lmem_port_arbiter_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_valid (cand),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .g         (g),
    .any       (any)
  );

  // The granted requester is always valid, so a grant is an accept.
  assign act       = any & ~rst;
  assign req_ready = act ? grant : '0;
  assign mem_we    = act & req_we[g];
  assign mem_addr  = act ? req_addr[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_data  = act ? req_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      tag_vld_p1  <= 1'b0;
      rsp_hold_p1 <= '0;
`ifdef LMEM_ARB_LOCK_EN
      state       <= ARB;
      owner       <= '0;
      lock_cnt    <= '0;
`endif
    end else begin
      tag_vld_p1 <= act & ~req_we[g];
      if (tag_vld_p1) rsp_hold_p1 <= mem_q;
      if (act) begin
`ifdef LMEM_ARB_LOCK_EN
        if (state == ARB) begin
          if (req_lock[g] && LOCK_MAX > 1) begin
            state    <= LOCKED;
            owner    <= g;
            lock_cnt <= CW'(1);
          end else begin
            rr_ptr <= next_id(g);
          end
        end else begin
          // Release on an unlocked beat or after the LOCK_MAX-th locked beat.
          if (!req_lock[g] || lock_cnt == CW'(LOCK_MAX - 1)) begin
            state    <= ARB;
            lock_cnt <= '0;
            rr_ptr   <= next_id(owner);
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
`else
        rr_ptr <= next_id(g);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_g_p1 <= g;
  end

  // Stage p1: read response
  // A response whose cycle coincides with reset is dropped.
  assign rsp_valid = (tag_vld_p1 & ~rst) ? (NREQ'(1) << tag_g_p1) : '0;
  assign rsp_data  = (tag_vld_p1 & ~rst) ? mem_q : rsp_hold_p1;

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// tb_lmem_port_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared cycle by cycle against a transaction-level reference model.
// Lock scenarios are included when LMEM_ARB_LOCK_EN is defined.
module tb_lmem_port_arbiter;

  localparam int DW = 18;
  localparam int AW = 10;
  localparam int N  = 4;
  localparam int LM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, mem_data, mem_q;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;

  lmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREQ(N), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  // LMEM port model: registered read, write on we.
  logic [DW-1:0] lmem [0:1023];
  always @(posedge clk) begin
    mem_q <= lmem[mem_addr];
    if (mem_we) lmem[mem_addr] <= mem_data;
  end

  // Reference model state
  logic [DW-1:0] m_mem [0:1023];
  int            m_ptr, m_owner, m_cnt;
  bit            m_lock;
  bit            p_vld;
  int            p_idx;
  logic [DW-1:0] p_data, m_hold;
  int            errors = 0;
  int            checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst) return -1;
    if (m_lock) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic tick(output int g);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    g = exp_grant();
    a = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    d = (g >= 0) ? req_data[g*DW +: DW] : '0;
    check_eq("ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    check_eq("mem_we", 64'(mem_we), (g >= 0) ? 64'(req_we[g]) : 64'd0);
    check_eq("mem_addr", 64'(mem_addr), 64'(a));
    check_eq("mem_data", 64'(mem_data), 64'(d));
    check_eq("rsp_valid", 64'(rsp_valid), (p_vld && !rst) ? (64'd1 << p_idx) : 64'd0);
    check_eq("rsp_data", 64'(rsp_data), (p_vld && !rst) ? 64'(p_data) : 64'(m_hold));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_cnt = 0; p_vld = 0; m_hold = '0;
    end else begin
      if (p_vld) m_hold = p_data;
      p_vld = 0;
      if (g >= 0) begin
        if (!req_we[g]) begin
          p_vld = 1; p_idx = g; p_data = m_mem[a];
        end else begin
          m_mem[a] = d;
        end
`ifdef LMEM_ARB_LOCK_EN
        if (m_lock) begin
          m_cnt++;
          if (!req_lock[g] || m_cnt == LM) begin
            m_lock = 0; m_ptr = (g + 1) % N;
          end
        end else if (req_lock[g] && LM > 1) begin
          m_lock = 1; m_owner = g; m_cnt = 1;
        end else begin
          m_ptr = (g + 1) % N;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic new_req(input int i);
    req_valid[i] = ($urandom_range(0, 3) != 0);
    req_we[i]    = 1'($urandom_range(0, 1));
`ifdef LMEM_ARB_LOCK_EN
    req_lock[i]  = ($urandom_range(0, 2) == 0);
`else
    req_lock[i]  = 1'($urandom_range(0, 1));
`endif
    req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
    req_data[i*DW +: DW] = DW'($urandom);
  endtask

  int g;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      lmem[i] = '0; m_mem[i] = '0;
    end
    lmem[5] = 18'h2A; m_mem[5] = 18'h2A;
    m_ptr = 0; m_lock = 0; m_owner = 0; m_cnt = 0; p_vld = 0; p_idx = 0;
    p_data = '0; m_hold = '0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    req_valid = 4'b1111;
    tick(g);
    tick(g);
    rst = 1'b0;
    req_valid = '0;
    tick(g);

    // Single read by requester 1
    req_valid = 4'b0010; req_we = '0; req_addr[1*AW +: AW] = 10'h005;
    tick(g);
    req_valid = '0;
    #1;
    check_eq("t1_rsp_valid", 64'(rsp_valid), 64'h2);
    check_eq("t1_rsp_data", 64'(rsp_data), 64'h2A);
    tick(g);

    // Reset with a read in flight
    req_valid = 4'b0001; req_addr[0 +: AW] = 10'h005;
    tick(g);
    rst = 1'b1; req_valid = 4'b1000;
    #1;
    check_eq("t4_rsp_dropped", 64'(rsp_valid), 64'h0);
    check_eq("t4_ready_in_rst", 64'(req_ready), 64'h0);
    tick(g);
    tick(g);
    rst = 1'b0; req_valid = '0;
    #1;
    check_eq("t4_rsp_after_rst", 64'(rsp_valid), 64'h0);
    tick(g);

    // All requesters continuously valid: strict rotation from 0
    req_valid = 4'b1111; req_we = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i + 4);
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t2_rotation", 64'(req_ready), 64'd1 << (i % N));
      if (i > 0) check_eq("t2_rsp_follow", 64'(rsp_valid), 64'd1 << ((i - 1) % N));
      tick(g);
    end
    req_valid = '0;
    tick(g);

    // Write then read of the top address
    req_valid = 4'b0100; req_we = 4'b0100;
    req_addr[2*AW +: AW] = 10'h3FF; req_data[2*DW +: DW] = 18'h1234;
    tick(g);
    req_valid = 4'b0001; req_we = '0; req_addr[0 +: AW] = 10'h3FF;
    #1;
    check_eq("t3_no_write_rsp", 64'(rsp_valid), 64'h0);
    tick(g);
    req_valid = '0;
    #1;
    check_eq("t3_rsp_valid", 64'(rsp_valid), 64'h1);
    check_eq("t3_rsp_data", 64'(rsp_data), 64'h1234);
    tick(g);

`ifdef LMEM_ARB_LOCK_EN
    // Locked burst by requester 3 while requester 0 waits
    req_valid = 4'b1001; req_we = 4'b1000; req_addr[3*AW +: AW] = 10'h010;
    for (int b = 0; b < 4; b++) begin
      req_lock = (b < 3) ? 4'b1000 : 4'b0000;
      #1;
      check_eq("t5_owner", 64'(req_ready), 64'h8);
      tick(g);
    end
    req_lock = '0; req_valid = 4'b0001;
    #1;
    check_eq("t5_waiter", 64'(req_ready), 64'h1);
    tick(g);

    // Forced release after LOCK_MAX locked accepts
    req_valid = 4'b0110; req_we = 4'b0110; req_lock = 4'b0010;
    for (int b = 0; b < LM; b++) begin
      #1;
      check_eq("t6_locked", 64'(req_ready), 64'h2);
      tick(g);
    end
    #1;
    check_eq("t6_release", 64'(req_ready), 64'h4);
    tick(g);
    req_valid = '0; req_lock = '0;
    tick(g);
`endif

    // Randomized traffic; pending requests stay stable until accepted.
    for (int i = 0; i < N; i++) new_req(i);
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      tick(g);
      for (int i = 0; i < N; i++) begin
        if (i == g || !req_valid[i]) new_req(i);
      end
    end
    rst = 1'b0;
    req_valid = '0;
    tick(g);
    tick(g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
